// File: rtl/minilab_pkg.sv
// minilab_pkg: shared state encoding and default sizes for the fifo fill controller
package minilab_pkg;
    typedef enum logic [1:0] {IDLE, FILL_BUF, FILL_FIFO, DONE} state_t;
    localparam int NUM_WORDS = 9;
    localparam int LANES = 8;
    localparam int DATA_W = 8;
endpackage

// File: rtl/word_buf.sv
// word_buf: NUM_WORDS-entry word store with one write port and a byte-select read across all entries
//   clk   - clock
//   we    - write enable, stores wdata at waddr
//   sel   - byte index, 0 selects the most significant byte of each word
//   rdata - byte sel of entry i on lane i
module word_buf #(
    parameter int NUM_WORDS = minilab_pkg::NUM_WORDS,
    parameter int LANES = minilab_pkg::LANES,
    parameter int DATA_W = minilab_pkg::DATA_W,
    parameter int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    parameter int BW = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [WW-1:0]               waddr,
    input  logic [LANES*DATA_W-1:0]     wdata,
    input  logic [BW-1:0]               sel,
    output logic [NUM_WORDS*DATA_W-1:0] rdata
);
    logic [LANES*DATA_W-1:0] mem [NUM_WORDS];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_lane
        assign rdata[i*DATA_W +: DATA_W] = mem[i][(LANES - 1 - 32'(sel))*DATA_W +: DATA_W];
    end
endmodule

// File: rtl/fifo_fill_ctrl.sv
// fifo_fill_ctrl: fetches NUM_WORDS words from memory, then streams them byte-wise MSB first into NUM_WORDS FIFOs
//   start                       - level, begins a run from IDLE or DONE
//   mem_address/mem_read        - read request, held while mem_waitrequest
//   mem_readdata/mem_readdatavalid - returned word
//   fifo_full/fifo_wren/fifo_wdata - per-FIFO flow control, all lanes pushed together
//   busy/done                   - run in progress / run finished
module fifo_fill_ctrl #(
    parameter int NUM_WORDS = minilab_pkg::NUM_WORDS,
    parameter int LANES = minilab_pkg::LANES,
    parameter int DATA_W = minilab_pkg::DATA_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic [3:0]                  mem_address,
    output logic                        mem_read,
    input  logic                        mem_waitrequest,
    input  logic [LANES*DATA_W-1:0]     mem_readdata,
    input  logic                        mem_readdatavalid,
    input  logic [NUM_WORDS-1:0]        fifo_full,
    output logic [NUM_WORDS-1:0]        fifo_wren,
    output logic [NUM_WORDS*DATA_W-1:0] fifo_wdata,
    output logic                        busy,
    output logic                        done
);
    import minilab_pkg::*;
    localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int BW = (LANES > 1) ? $clog2(LANES) : 1;
    state_t                      state;
    logic [WW-1:0]               wcnt;
    logic [BW-1:0]               bcnt;
    logic                        pending;
    logic                        store;
    logic [NUM_WORDS*DATA_W-1:0] lane_bytes;
    // data is taken only while a read is outstanding, so stray or post-reset valids are dropped
    assign store = state == FILL_BUF && pending && mem_readdatavalid;
    assign mem_address = 4'(wcnt);
    assign busy = state == FILL_BUF || state == FILL_FIFO;
    assign done = state == DONE;
    word_buf #(.NUM_WORDS(NUM_WORDS), .LANES(LANES), .DATA_W(DATA_W)) u_buf (
        .clk(clk),
        .we(store),
        .waddr(wcnt),
        .wdata(mem_readdata),
        .sel(bcnt),
        .rdata(lane_bytes)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            wcnt <= '0;
            bcnt <= '0;
            pending <= 1'b0;
            mem_read <= 1'b0;
            fifo_wren <= '0;
            fifo_wdata <= '0;
        end else begin
            fifo_wren <= '0;
            case (state)
                IDLE, DONE:
                    if (start) begin
                        state <= FILL_BUF;
                        wcnt <= '0;
                        bcnt <= '0;
                        pending <= 1'b0;
                        mem_read <= 1'b1;
                    end
                FILL_BUF:
                    if (mem_read && !mem_waitrequest) begin
                        mem_read <= 1'b0;
                        pending <= 1'b1;
                    end else if (store) begin
                        pending <= 1'b0;
                        if (wcnt == WW'(NUM_WORDS - 1)) state <= FILL_FIFO;
                        else begin
                            wcnt <= wcnt + 1'b1;
                            mem_read <= 1'b1;
                        end
                    end
                FILL_FIFO:
                    // any full lane stalls every lane so all FIFOs see the same byte sequence
                    if (fifo_full == '0) begin
                        fifo_wren <= '1;
                        fifo_wdata <= lane_bytes;
                        if (bcnt == BW'(LANES - 1)) state <= DONE;
                        else bcnt <= bcnt + 1'b1;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
